// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch unit is the master: it raises imem_req and drives imem_addr until imem_ack.
interface fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch / PC-sequencing stage: fetches one word, holds it until
// retire, then advances the PC sequentially or to the branch target.
module fetch_unit #(
  parameter int RETIRE_CNT_W = 32
) (
  input  logic                    CLK,
  input  logic                    resetl,
  input  logic [63:0]             startpc,
  fetch_unit_if.master            imem,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  output logic [63:0]             pc,
  input  logic                    retire,
  input  logic                    branch,
  input  logic                    uncond_branch,
  input  logic                    zero,
  input  logic [63:0]             branch_offset,
  output logic                    fault,
  output logic [RETIRE_CNT_W-1:0] retire_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [RETIRE_CNT_W-1:0] CNT_ONE = {{(RETIRE_CNT_W-1){1'b0}}, 1'b1};

  state_t                  state_reg;
  logic [63:0]             pc_reg;
  logic [31:0]             instr_reg;
  logic                    instr_valid_reg;
  logic                    fault_reg;
  logic [RETIRE_CNT_W-1:0] retire_count_reg;

  logic                    taken;
  logic [63:0]             offset_bytes;
  logic [63:0]             pc_next;

  // Branch controls are only consumed on a retire edge in HOLD, so any X they
  // carry in other cycles never reaches a register.
  always_comb begin
    taken        = uncond_branch | (branch & zero);
    offset_bytes = branch_offset << 2;
    pc_next      = pc_reg + 64'd4;
    if (taken) begin
      pc_next = pc_reg + offset_bytes;
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_reg        <= BOOT;
      pc_reg           <= 64'd0;
      instr_reg        <= 32'd0;
      instr_valid_reg  <= 1'b0;
      fault_reg        <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      case (state_reg)
        BOOT: begin
          pc_reg <= startpc;
          if (startpc[1:0] != 2'b00) begin
            fault_reg <= 1'b1;
            state_reg <= FAULT;
          end else begin
            state_reg <= FETCH;
          end
        end

        FETCH: begin
          if (imem.imem_ack) begin
            instr_reg       <= imem.imem_rdata;
            instr_valid_reg <= 1'b1;
            state_reg       <= HOLD;
          end
        end

        HOLD: begin
          if (retire) begin
            retire_count_reg <= retire_count_reg + CNT_ONE;
            instr_valid_reg  <= 1'b0;
            pc_reg           <= pc_next;
            state_reg        <= FETCH;
          end
        end

        FAULT: begin
          fault_reg       <= 1'b1;
          instr_valid_reg <= 1'b0;
        end

        default: state_reg <= FAULT;
      endcase
    end
  end

  // The request is a pure decode of the state register; the address is the PC itself.
  assign imem.imem_req  = (state_reg == FETCH);
  assign imem.imem_addr = pc_reg;

  assign instr        = instr_reg;
  assign instr_valid  = instr_valid_reg;
  assign pc           = pc_reg;
  assign fault        = fault_reg;
  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: boot, sequencing, branches,
// handshake timing, misaligned boot and reset during a fetch.
module tb_fetch_unit;

  logic        CLK;
  logic        resetl;
  logic [63:0] startpc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [63:0] pc;
  logic        retire;
  logic        branch;
  logic        uncond_branch;
  logic        zero;
  logic [63:0] branch_offset;
  logic        fault;
  logic [31:0] retire_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RETIRE_CNT_W(32)) dut (
    .CLK           (CLK),
    .resetl        (resetl),
    .startpc       (startpc),
    .imem          (bus.master),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .retire        (retire),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .fault         (fault),
    .retire_count  (retire_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Stimulus only: ack after 'delay' idle FETCH cycles with the given word.
  task automatic fetch_word(input int delay, input logic [31:0] word);
    for (int i = 0; i < delay; i++) tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Stimulus only: one retire edge, then the branch controls go to X.
  task automatic do_retire(input logic b, input logic u, input logic z, input logic [63:0] off);
    retire        = 1'b1;
    branch        = b;
    uncond_branch = u;
    zero          = z;
    branch_offset = off;
    tick();
    retire        = 1'b0;
    branch        = 1'bx;
    uncond_branch = 1'bx;
    zero          = 1'bx;
    branch_offset = 'x;
    exp_count     = exp_count + 32'd1;
  endtask

  task automatic test_reset();
    resetl = 1'b0;
    startpc = 64'h1000;
    tick();
    tick();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b want 0", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h want 0", instr); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", retire_count); end
    $display("reset: pc=%h req=%0b valid=%0b", pc, bus.imem_req, instr_valid);
  endtask

  task automatic test_boot();
    resetl = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL boot_req cyc%0d got %0b want 1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 64'h1000) begin errors++; $display("FAIL boot_addr cyc%0d got %h want 1000", i, bus.imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL boot_early_valid cyc%0d got %0b want 0", i, instr_valid); end
      if (i == 0) tick();
    end
    fetch_word(0, 32'h8B02_0020);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL boot_valid got %0b want 1", instr_valid); end
    checks++; if (instr !== 32'h8B02_0020) begin errors++; $display("FAIL boot_instr got %h want 8b020020", instr); end
    checks++; if (pc !== 64'h1000) begin errors++; $display("FAIL boot_pc got %h want 1000", pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_hold_req got %0b want 0", bus.imem_req); end
    $display("boot: pc=%h instr=%h valid=%0b", pc, instr, instr_valid);
  endtask

  task automatic test_sequential();
    do_retire(1'b0, 1'b0, 1'b0, 64'd0);
    checks++; if (pc !== 64'h1004) begin errors++; $display("FAIL seq1_pc got %h want 1004", pc); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL seq1_req got %0b want 1", bus.imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq1_valid got %0b want 0", instr_valid); end
    checks++; if (retire_count !== 32'd1) begin errors++; $display("FAIL seq1_count got %0d want 1", retire_count); end
    fetch_word(1, 32'h9100_0421);
    do_retire(1'b0, 1'b0, 1'b1, 64'd7);
    checks++; if (pc !== 64'h1008) begin errors++; $display("FAIL seq2_pc got %h want 1008", pc); end
    checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL seq2_count got %0d want 2", retire_count); end
    $display("sequential: pc=%h count=%0d", pc, retire_count);
  endtask

  task automatic test_branches();
    fetch_word(1, 32'h1400_0000);
    do_retire(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    checks++; if (pc !== 64'h1000) begin errors++; $display("FAIL uncond_pc got %h want 1000", pc); end
    fetch_word(0, 32'hB400_00A0);
    do_retire(1'b1, 1'b0, 1'b1, 64'd5);
    checks++; if (pc !== 64'h1014) begin errors++; $display("FAIL cbz_taken_pc got %h want 1014", pc); end
    fetch_word(0, 32'hB400_00A0);
    do_retire(1'b1, 1'b0, 1'b0, 64'd5);
    checks++; if (pc !== 64'h1018) begin errors++; $display("FAIL cbz_not_taken_pc got %h want 1018", pc); end
    // 0x1018 + 0xFFFF_FFFF_FFFF_F000 wraps to 0x18
    fetch_word(0, 32'h1400_0000);
    do_retire(1'b0, 1'b1, 1'b0, 64'h3FFF_FFFF_FFFF_FC00);
    checks++; if (pc !== 64'h18) begin errors++; $display("FAIL wrap_pc got %h want 18", pc); end
    checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL branch_count got %0d want %0d", retire_count, exp_count); end
    $display("branches: pc=%h count=%0d", pc, retire_count);
  endtask

  task automatic test_handshake();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL wait_req cyc%0d got %0b want 1", i, bus.imem_req); end
      checks++; if (bus.imem_addr !== 64'h18) begin errors++; $display("FAIL wait_addr cyc%0d got %h want 18", i, bus.imem_addr); end
      retire = 1'b1;
      tick();
    end
    retire = 1'b0;
    checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL fetch_retire_count got %0d want %0d", retire_count, exp_count); end
    fetch_word(0, 32'hAAAA_0001);
    checks++; if (instr !== 32'hAAAA_0001) begin errors++; $display("FAIL delayed_instr got %h want aaaa0001", instr); end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h5555_0002;
    tick();
    tick();
    bus.imem_ack = 1'b0;
    checks++; if (instr !== 32'hAAAA_0001) begin errors++; $display("FAIL hold_ack_instr got %h want aaaa0001", instr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL hold_ack_valid got %0b want 1", instr_valid); end
    do_retire(1'b0, 1'b0, 1'b0, 64'd0);
    fetch_word(0, 32'h1234_5678);
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_valid got %0b want 1", instr_valid); end
    checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL same_cycle_instr got %h want 12345678", instr); end
    checks++; if (pc !== 64'h1C) begin errors++; $display("FAIL same_cycle_pc got %h want 1c", pc); end
    $display("handshake: pc=%h instr=%h count=%0d", pc, instr, retire_count);
  endtask

  task automatic test_fault();
    resetl = 1'b0;
    startpc = 64'h1002;
    tick();
    resetl = 1'b1;
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_flag got %0b want 1", fault); end
    checks++; if (pc !== 64'h1002) begin errors++; $display("FAIL fault_pc got %h want 1002", pc); end
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack = 1'b1;
      retire = 1'b1;
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fault_req cyc%0d got %0b want 0", i, bus.imem_req); end
      tick();
    end
    bus.imem_ack = 1'b0;
    retire = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %0b want 1", fault); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fault_valid got %0b want 0", instr_valid); end
    checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL fault_count got %0d want 0", retire_count); end
    $display("fault: pc=%h fault=%0b req=%0b", pc, fault, bus.imem_req);
  endtask

  task automatic test_reset_mid_fetch();
    resetl = 1'b0;
    startpc = 64'h2000;
    tick();
    resetl = 1'b1;
    tick();
    checks++; if (bus.imem_addr !== 64'h2000) begin errors++; $display("FAIL mid_addr got %h want 2000", bus.imem_addr); end
    resetl = 1'b0;
    #1;
    checks++; if (pc !== 64'd0) begin errors++; $display("FAIL async_pc got %h want 0", pc); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL async_req got %0b want 0", bus.imem_req); end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    resetl = 1'b1;
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_valid got %0b want 0", instr_valid); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL stale_instr got %h want 0", instr); end
    checks++; if (pc !== 64'h2000) begin errors++; $display("FAIL restart_pc got %h want 2000", pc); end
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL restart_req got %0b want 1", bus.imem_req); end
    bus.imem_ack = 1'b0;
    fetch_word(2, 32'hF840_0000);
    checks++; if (instr !== 32'hF840_0000) begin errors++; $display("FAIL restart_instr got %h want f8400000", instr); end
    $display("reset_mid_fetch: pc=%h instr=%h valid=%0b", pc, instr, instr_valid);
  endtask

  initial begin
    resetl         = 1'b0;
    startpc        = 64'd0;
    retire         = 1'b0;
    branch         = 1'b0;
    uncond_branch  = 1'b0;
    zero           = 1'b0;
    branch_offset  = 64'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    test_reset();
    test_boot();
    test_sequential();
    test_branches();
    test_handshake();
    test_fault();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
